ahb_slave_if: RTL and testbench

- AHB-side slave front end of the AHB-to-APB bridge.
- Qualifies AHB transfers (valid) and decodes the address into a one-hot APB peripheral select (tempselx).
- Pipelines address, write data and direction by two cycles (one for direction) for the APB FSM controller.
- Drives a fixed OKAY response and a zero read-data bus; APB read data returns through the controller.

---
 rtl/ahb_apb_pkg.sv | 34 +++
 rtl/ahb_slv_addr_decode.sv | 34 +++
 rtl/ahb_slave_if.sv | 109 ++++++++++
 tb/tb_ahb_slave_if.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/ahb_apb_pkg.sv
// ahb_apb_pkg: shared constants for the AHB-to-APB bridge.
//   - HTRANS transfer-type codes and HRESP response codes.
//   - Base/limit addresses of the three APB peripheral regions.
//   - One-hot peripheral select encodings.
//   - Helper that tells whether a transfer type carries an address phase.
package ahb_apb_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    // Each region is 64 MiB; the window ends at REGION_LIMIT (exclusive).
    localparam logic [31:0] REGION0_BASE = 32'h8000_0000;
    localparam logic [31:0] REGION1_BASE = 32'h8400_0000;
    localparam logic [31:0] REGION2_BASE = 32'h8800_0000;
    localparam logic [31:0] REGION_LIMIT = 32'h8C00_0000;

    localparam logic [2:0] SELX_NONE = 3'b000;
    localparam logic [2:0] SELX_P0   = 3'b001;
    localparam logic [2:0] SELX_P1   = 3'b010;
    localparam logic [2:0] SELX_P2   = 3'b100;

    // NONSEQ and SEQ are the only transfer types that request a data phase.
    function automatic logic trans_active(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_slv_addr_decode.sv
// ahb_slv_addr_decode: combinational AHB address decoder.
//   addr     in  [ADDR_W-1:0]  address-phase address
//   selx     out [2:0]         one-hot APB peripheral select (000 outside window)
//   in_range out               address falls inside [8000_0000, 8C00_0000)
module ahb_slv_addr_decode
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [2:0]        selx,
    output logic              in_range
);

    // Region lookup: ordered compares against the region bases.
    always_comb begin
        selx     = SELX_NONE;
        in_range = 1'b0;
        if ((addr >= REGION0_BASE) && (addr < REGION1_BASE)) begin
            selx     = SELX_P0;
            in_range = 1'b1;
        end else if ((addr >= REGION1_BASE) && (addr < REGION2_BASE)) begin
            selx     = SELX_P1;
            in_range = 1'b1;
        end else if ((addr >= REGION2_BASE) && (addr < REGION_LIMIT)) begin
            selx     = SELX_P2;
            in_range = 1'b1;
        end else begin
            selx     = SELX_NONE;
            in_range = 1'b0;
        end
    end

endmodule

// File: rtl/ahb_slave_if.sv
// ahb_slave_if: AHB-side slave front end of the AHB-to-APB bridge.
//   Hclk, Hresetn            clock, asynchronous active-low reset
//   Hwrite, Hreadyin, Htrans AHB control inputs
//   Haddr, Hwdata            AHB address / write data
//   valid                    qualified, in-range transfer (combinational)
//   Haddr1/2, Hwdata1/2      address / write data delayed 1 and 2 cycles
//   Hwritereg                Hwrite delayed 1 cycle
//   tempselx                 one-hot peripheral select (combinational)
//   Hrdata                   always zero; APB read data returns via the controller
//   Hresp                    OKAY, or registered ERROR for out-of-window
//                            transfers when AHB_SLV_ERRRESP_EN is defined
module ahb_slave_if
    import ahb_apb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              Hclk,
    input  logic              Hresetn,
    input  logic              Hwrite,
    input  logic              Hreadyin,
    input  logic [1:0]        Htrans,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [DATA_W-1:0] Hwdata,
    output logic              valid,
    output logic [ADDR_W-1:0] Haddr1,
    output logic [ADDR_W-1:0] Haddr2,
    output logic [DATA_W-1:0] Hwdata1,
    output logic [DATA_W-1:0] Hwdata2,
    output logic              Hwritereg,
    output logic [2:0]        tempselx,
    output logic [DATA_W-1:0] Hrdata,
    output logic [1:0]        Hresp
);

    logic [2:0]        selx_s;
    logic              in_range_s;
    logic              active_s;
    logic              valid_s;
    logic [ADDR_W-1:0] haddr1_r;
    logic [ADDR_W-1:0] haddr2_r;
    logic [DATA_W-1:0] hwdata1_r;
    logic [DATA_W-1:0] hwdata2_r;
    logic              hwrite_r;

    ahb_slv_addr_decode #(
        .ADDR_W (ADDR_W)
    ) u_decode (
        .addr     (Haddr),
        .selx     (selx_s),
        .in_range (in_range_s)
    );

    // Transfer qualification; intentionally independent of reset.
    always_comb begin
        active_s = Hreadyin && trans_active(Htrans);
        if (active_s && in_range_s) begin
            valid_s = 1'b1;
        end else begin
            valid_s = 1'b0;
        end
    end

    // Address/data/direction pipeline, advancing every cycle regardless of Hreadyin.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            haddr1_r  <= {ADDR_W{1'b0}};
            haddr2_r  <= {ADDR_W{1'b0}};
            hwdata1_r <= {DATA_W{1'b0}};
            hwdata2_r <= {DATA_W{1'b0}};
            hwrite_r  <= 1'b0;
        end else begin
            haddr1_r  <= Haddr;
            haddr2_r  <= haddr1_r;
            hwdata1_r <= Hwdata;
            hwdata2_r <= hwdata1_r;
            hwrite_r  <= Hwrite;
        end
    end

`ifdef AHB_SLV_ERRRESP_EN
    logic [1:0] hresp_r;

    // ERROR is flagged one cycle after an active transfer misses the window.
    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            hresp_r <= HRESP_OKAY;
        end else if (active_s && !in_range_s) begin
            hresp_r <= HRESP_ERROR;
        end else begin
            hresp_r <= HRESP_OKAY;
        end
    end

    assign Hresp = hresp_r;
`else
    assign Hresp = HRESP_OKAY;
`endif

    assign valid     = valid_s;
    assign tempselx  = selx_s;
    assign Haddr1    = haddr1_r;
    assign Haddr2    = haddr2_r;
    assign Hwdata1   = hwdata1_r;
    assign Hwdata2   = hwdata2_r;
    assign Hwritereg = hwrite_r;
    assign Hrdata    = {DATA_W{1'b0}};

endmodule

// File: tb/tb_ahb_slave_if.sv
// tb_ahb_slave_if: directed self-checking bench for ahb_slave_if.
// Inputs change on the falling edge; registered outputs are sampled 1 time
// unit after the rising edge, combinational outputs 1 unit after the drive.
module tb_ahb_slave_if;

    logic        Hclk;
    logic        Hresetn;
    logic        Hwrite;
    logic        Hreadyin;
    logic [1:0]  Htrans;
    logic [31:0] Haddr;
    logic [31:0] Hwdata;
    logic        valid;
    logic [31:0] Haddr1;
    logic [31:0] Haddr2;
    logic [31:0] Hwdata1;
    logic [31:0] Hwdata2;
    logic        Hwritereg;
    logic [2:0]  tempselx;
    logic [31:0] Hrdata;
    logic [1:0]  Hresp;

    int checks   = 0;
    int failures = 0;

    ahb_slave_if #(
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .Hclk      (Hclk),
        .Hresetn   (Hresetn),
        .Hwrite    (Hwrite),
        .Hreadyin  (Hreadyin),
        .Htrans    (Htrans),
        .Haddr     (Haddr),
        .Hwdata    (Hwdata),
        .valid     (valid),
        .Haddr1    (Haddr1),
        .Haddr2    (Haddr2),
        .Hwdata1   (Hwdata1),
        .Hwdata2   (Hwdata2),
        .Hwritereg (Hwritereg),
        .tempselx  (tempselx),
        .Hrdata    (Hrdata),
        .Hresp     (Hresp)
    );

    initial Hclk = 1'b0;
    always #5 Hclk = ~Hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic [1:0] tr, input logic [31:0] a,
                         input logic [31:0] d, input logic w);
        @(negedge Hclk);
        Hreadyin = rdy;
        Htrans   = tr;
        Haddr    = a;
        Hwdata   = d;
        Hwrite   = w;
        #1;
    endtask

    task automatic after_edge();
        @(posedge Hclk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

    initial begin
        Hresetn  = 1'b0;
        Hwrite   = 1'b1;
        Hreadyin = 1'b1;
        Htrans   = 2'b10;
        Haddr    = 32'h8000_1000;
        Hwdata   = 32'hDEAD_BEEF;

        // Reset held across clock edges: pipeline stays clear.
        after_edge();
        after_edge();
        chk("rst_haddr1",    Haddr1,    32'h0);
        chk("rst_haddr2",    Haddr2,    32'h0);
        chk("rst_hwdata1",   Hwdata1,   32'h0);
        chk("rst_hwdata2",   Hwdata2,   32'h0);
        chk("rst_hwritereg", {31'h0, Hwritereg}, 32'h0);
        chk("rst_hresp",     {30'h0, Hresp},     32'h0);
        chk("rst_hrdata",    Hrdata,    32'h0);
        chk("rst_valid",     {31'h0, valid},     32'h1);
        chk("rst_tempselx",  {29'h0, tempselx},  32'h1);

        // Release on a falling edge; outputs hold until the next rising edge.
        @(negedge Hclk);
        Hresetn = 1'b1;
        #1;
        chk("rel_haddr1_hold", Haddr1, 32'h0);
        after_edge();
        chk("rel_haddr1",    Haddr1,    32'h8000_1000);
        chk("rel_hwdata1",   Hwdata1,   32'hDEAD_BEEF);
        chk("rel_hwritereg", {31'h0, Hwritereg}, 32'h1);

        // Out-of-range address just past the window.
        drive(1'b1, 2'b10, 32'h8C00_1234, 32'h8500_0000, 1'b0);
        chk("oor_valid",    {31'h0, valid},    32'h0);
        chk("oor_tempselx", {29'h0, tempselx}, 32'h0);
        after_edge();
        chk("oor_haddr1",   Haddr1,  32'h8C00_1234);
        chk("oor_hwdata1",  Hwdata1, 32'h8500_0000);
        chk("oor_haddr2",   Haddr2,  32'h8000_1000);
        chk("oor_hwdata2",  Hwdata2, 32'hDEAD_BEEF);

        // Not ready: select decodes, valid is suppressed until Hreadyin rises.
        drive(1'b0, 2'b11, 32'h8040_0000, 32'h0, 1'b0);
        chk("nrdy_valid",    {31'h0, valid},    32'h0);
        chk("nrdy_tempselx", {29'h0, tempselx}, 32'h1);
        drive(1'b1, 2'b11, 32'h8040_0000, 32'h0, 1'b0);
        chk("rdy_valid",     {31'h0, valid},    32'h1);

        // Region sweep including boundaries.
        drive(1'b1, 2'b10, 32'h8000_0000, 32'h0, 1'b0);
        chk("r0_lo_sel",   {29'h0, tempselx}, 32'h1);
        chk("r0_lo_valid", {31'h0, valid},    32'h1);
        drive(1'b1, 2'b10, 32'h8500_0000, 32'h0, 1'b0);
        chk("r1_sel",      {29'h0, tempselx}, 32'h2);
        chk("r1_valid",    {31'h0, valid},    32'h1);
        drive(1'b1, 2'b10, 32'h83FF_FFFF, 32'h0, 1'b0);
        chk("r0_hi_sel",   {29'h0, tempselx}, 32'h1);
        drive(1'b1, 2'b10, 32'h8800_0000, 32'h0, 1'b0);
        chk("r2_lo_sel",   {29'h0, tempselx}, 32'h4);
        drive(1'b1, 2'b10, 32'h8BFF_FFFF, 32'h0, 1'b0);
        chk("r2_hi_sel",   {29'h0, tempselx}, 32'h4);
        chk("r2_hi_valid", {31'h0, valid},    32'h1);
        drive(1'b1, 2'b10, 32'h7FFF_FFFF, 32'h0, 1'b0);
        chk("below_sel",   {29'h0, tempselx}, 32'h0);
        chk("below_valid", {31'h0, valid},    32'h0);
        drive(1'b1, 2'b10, 32'h8C00_0000, 32'h0, 1'b0);
        chk("limit_sel",   {29'h0, tempselx}, 32'h0);
        chk("limit_valid", {31'h0, valid},    32'h0);
        drive(1'b1, 2'b00, 32'h8000_0000, 32'h0, 1'b0);
        chk("idle_valid",  {31'h0, valid},    32'h0);
        chk("idle_sel",    {29'h0, tempselx}, 32'h1);
        drive(1'b1, 2'b01, 32'h8000_0000, 32'h0, 1'b0);
        chk("busy_valid",  {31'h0, valid},    32'h0);

        // Pipeline: A, B, C with Hwrite 1, 0, 1.
        drive(1'b1, 2'b10, 32'h8000_00A0, 32'h1111_1111, 1'b1);
        after_edge();
        chk("pipe_a_haddr1", Haddr1, 32'h8000_00A0);
        chk("pipe_a_hwreg",  {31'h0, Hwritereg}, 32'h1);
        drive(1'b1, 2'b11, 32'h8400_00B0, 32'h2222_2222, 1'b0);
        after_edge();
        chk("pipe_b_haddr2", Haddr2, 32'h8000_00A0);
        chk("pipe_b_hwdata2", Hwdata2, 32'h1111_1111);
        chk("pipe_b_hwreg",  {31'h0, Hwritereg}, 32'h0);
        drive(1'b1, 2'b11, 32'h8800_00C0, 32'h3333_3333, 1'b1);
        after_edge();
        chk("pipe_c_haddr1", Haddr1, 32'h8800_00C0);
        chk("pipe_c_haddr2", Haddr2, 32'h8400_00B0);
        chk("pipe_c_hwdata2", Hwdata2, 32'h2222_2222);
        chk("pipe_c_hwreg",  {31'h0, Hwritereg}, 32'h1);

        // Error response to an out-of-window NONSEQ, then back to OKAY on IDLE.
        drive(1'b1, 2'b10, 32'h9000_0000, 32'h0, 1'b0);
        after_edge();
`ifdef AHB_SLV_ERRRESP_EN
        chk("err_hresp",  {30'h0, Hresp}, 32'h1);
`else
        chk("err_hresp",  {30'h0, Hresp}, 32'h0);
`endif
        drive(1'b1, 2'b00, 32'h9000_0000, 32'h0, 1'b0);
        after_edge();
        chk("idle_hresp", {30'h0, Hresp}, 32'h0);
        chk("hrdata_run", Hrdata, 32'h0);

        // Asynchronous reset mid-cycle: pipeline clears before the next edge.
        drive(1'b1, 2'b10, 32'h8400_0010, 32'h5555_5555, 1'b1);
        after_edge();
        chk("mid_pre_haddr1", Haddr1, 32'h8400_0010);
        #2;
        Hresetn = 1'b0;
        #1;
        chk("mid_haddr1",  Haddr1,  32'h0);
        chk("mid_haddr2",  Haddr2,  32'h0);
        chk("mid_hwdata1", Hwdata1, 32'h0);
        chk("mid_hwreg",   {31'h0, Hwritereg}, 32'h0);
        chk("mid_valid",   {31'h0, valid},    32'h1);
        chk("mid_sel",     {29'h0, tempselx}, 32'h2);
        chk("mid_hresp",   {30'h0, Hresp},    32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
